// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers.
//
// Accepts one mult/multu/div/divu request at a time and holds the pipeline
// through stall_req while it runs. mthi/mtlo write HI/LO directly in one cycle.
// Results become visible exactly MULT_CYCLES or DIV_CYCLES edges after the
// accept edge.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-low reset
//   start     - single-cycle issue request
//   op        - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   A, B      - operands (rs, rt)
//   busy      - registered, high while an operation is in flight
//   stall_req - busy or a multi-cycle op being requested this cycle
//   HI, LO    - registered result registers
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
    localparam int unsigned CntW      = (CntBits > 4) ? CntBits : 4;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [2:0]      op_q, op_d;

    logic            is_mdop;
    logic            div_ovf;
    logic [31:0]     sdiv_b;
    logic [31:0]     udiv_b;
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     quo_s, rem_s;
    logic [31:0]     quo_u, rem_u;

    assign is_mdop = (op >= OpMult) && (op <= OpDivu);

    // Arithmetic works on the latched operands only, so A/B may change freely
    // while the operation runs.
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divide-by-zero is never written back, and the one overflowing signed
    // case (INT_MIN / -1) yields INT_MIN rem 0, which is exactly a_q / 1.
    // Substituting 1 keeps the dividers free of undefined inputs.
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sdiv_b  = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
    assign udiv_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quo_s   = $signed(a_q) / $signed(sdiv_b);
    assign rem_s   = $signed(a_q) % $signed(sdiv_b);
    assign quo_u   = a_q / udiv_b;
    assign rem_u   = a_q % udiv_b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        stall_req = busy_q | (start & is_mdop);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mdop) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op;
                        busy_d  = 1'b1;
                        state_d = StRun;
                        cnt_d   = ((op == OpMult) || (op == OpMultu)) ? MultLoad : DivLoad;
                    end else if (op == OpMthi) begin
                        hi_d = A;
                    end else if (op == OpMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                // Requests arriving here are ignored; the hazard unit holds them.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                    case (op_q)
                        OpMult: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OpMultu: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OpDiv: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_s;
                                lo_d = quo_s;
                            end
                        end
                        OpDivu: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_u;
                                lo_d = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a transaction-level model:
// an accepted op computes its result with plain integer arithmetic and
// publishes it after the configured number of edges.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    // Reference model state.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;    // edges until the pending result lands
    bit          m_wr = 1'b0;   // pending result will be written
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0;
        m_lo = '0;
        m_left = 0;
        m_wr = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, pu;
        logic [63:0]     v;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = a;
            ub = b;
            m_wr = 1'b1;
            case (o)
                3'd1: begin
                    v = sa * sb;
                    m_phi = v[63:32]; m_plo = v[31:0]; m_left = MC;
                end
                3'd2: begin
                    pu = ua * ub; v = pu;
                    m_phi = v[63:32]; m_plo = v[31:0]; m_left = MC;
                end
                3'd3: begin
                    m_left = DC;
                    if (sb == 0) m_wr = 1'b0;
                    else begin
                        q = sa / sb; r = sa - q * sb;
                        v = q; m_plo = v[31:0];
                        v = r; m_phi = v[31:0];
                    end
                end
                3'd4: begin
                    m_left = DC;
                    if (ub == 0) m_wr = 1'b0;
                    else begin
                        v = ua / ub; m_plo = v[31:0];
                        v = ua % ub; m_phi = v[31:0];
                    end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // Called 1 time unit after a rising edge; drives one cycle of inputs.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        logic exp_stall;
        start = s; op = o; A = a; B = b;
        #1;
        exp_stall = (m_left > 0) || (s && o >= 3'd1 && o <= 3'd4);
        check("stall_req", stall_req, exp_stall);
        @(posedge clk);
        model_edge(s, o, a, b);
        #1;
        check("busy", busy, m_left > 0);
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
        if (busy) busy_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom);
    endtask

    // Pulse reset low for about half a clock, between two rising edges.
    task automatic pulse_reset();
        start = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        s;
        logic [2:0]  o;
        logic [31:0] a, b;

        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        #2;
        check("por_busy", busy, 1'b0);
        check("por_stall", stall_req, 1'b0);
        check("por_HI", HI, 32'd0);
        check("por_LO", LO, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Scenario 1: signed mult.
        busy_cnt = 0;
        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MC);
        check("s1_busy_cycles", busy_cnt, MC);
        check("s1_HI", HI, 32'hFFFF_FFFF);
        check("s1_LO", LO, 32'hFFFF_FFFA);

        // Scenario 2: unsigned mult.
        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MC);
        check("s2_HI", HI, 32'hFFFF_FFFE);
        check("s2_LO", LO, 32'h0000_0001);

        // Scenario 3: div and divu of -7 by 2.
        busy_cnt = 0;
        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        check("s3_busy_cycles", busy_cnt, DC);
        check("s3_div_LO", LO, 32'hFFFF_FFFD);
        check("s3_div_HI", HI, 32'hFFFF_FFFF);
        step(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        check("s3_divu_LO", LO, 32'h7FFF_FFFC);
        check("s3_divu_HI", HI, 32'h0000_0001);

        // INT_MIN / -1.
        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        check("ovf_LO", LO, 32'h8000_0000);
        check("ovf_HI", HI, 32'd0);

        // Scenario 4: divide by zero leaves preloaded HI/LO.
        step(1'b1, 3'd5, 32'h11, 32'd0);
        step(1'b1, 3'd6, 32'h22, 32'd0);
        busy_cnt = 0;
        step(1'b1, 3'd3, 32'd1234, 32'd0);
        idle(DC);
        check("s4_busy_cycles", busy_cnt, DC);
        check("s4_HI", HI, 32'h11);
        check("s4_LO", LO, 32'h22);

        // Scenario 5: requests during RUN are ignored.
        step(1'b1, 3'd1, 32'd2, 32'd3);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1, 3'd6, 32'h55, 32'd0);
        step(1'b1, 3'd3, 32'd9, 32'd3);
        idle(MC);
        check("s5_HI", HI, 32'd0);
        check("s5_LO", LO, 32'd6);

        // Scenario 6: reset mid-divide discards the result.
        step(1'b1, 3'd4, 32'd100, 32'd7);
        idle(3);
        pulse_reset();
        idle(DC + 2);
        check("s6_noresult_LO", LO, 32'd0);
        check("s6_noresult_HI", HI, 32'd0);
        step(1'b1, 3'd2, 32'd4, 32'd5);
        idle(MC);
        check("s6_LO", LO, 32'd20);

        // Random traffic, including hazards the hazard unit would normally block.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                s = ($urandom_range(0, 1) == 1);
                o = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 15))
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = 32'($urandom_range(1, 9));
                    default: ;
                endcase
                step(s, o, a, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port start, input, 1, single-cycle request from EX stage to issue op.
REQ-006 Port op, input, 3, operation code:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mthi
- 6 mtlo
- 7 reserved
REQ-007 Port A, input, 32, operand rs (dividend / multiplicand / mthi-mtlo source).
REQ-008 Port B, input, 32, operand rt (divisor / multiplier); already forwarded or extended upstream.
REQ-009 Port busy, output, 1, registered; high while an operation is in flight.
REQ-010 Port stall_req, output, 1, combinational; equals busy OR (start AND op in 1..4); consumed by the hazard unit.
REQ-011 Port HI, output, 32, registered HI value.
REQ-012 Port LO, output, 32, registered LO value.

Function
REQ-013 The module SHALL use states IDLE and RUN, plus a down-counter of 4 bits minimum that is sized to the larger of the two cycle parameters.
REQ-014 In IDLE, when start=1 and op is 1..4, the module SHALL latch A, B and op at that edge, enter RUN, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 In RUN, busy SHALL be 1 and the counter SHALL decrement each edge.
REQ-016 The edge on which the counter reaches 0 SHALL write HI/LO, clear busy and return to IDLE; the result is visible the cycle after busy falls. Total latency from the accept edge to HI/LO valid is exactly MULT_CYCLES or DIV_CYCLES edges.
REQ-017 mult SHALL produce the signed 64-bit product; multu SHALL produce the unsigned 64-bit product. HI gets bits [63:32] and LO gets bits [31:0].
REQ-018 div and divu SHALL set LO to the quotient and HI to the remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-019 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 Divide by zero (B=0 latched) SHALL run the full DIV_CYCLES and then leave HI/LO unchanged.
REQ-021 mthi/mtlo with start=1 in IDLE SHALL write A into HI/LO at that edge, with no busy assertion and stall_req=0.
REQ-022 start while busy=1 SHALL be ignored for all ops, and the in-flight operation SHALL be unaffected. The hazard unit guarantees no issue under stall_req.
REQ-023 op 0, op 7, or start=0 SHALL change no state.
REQ-024 Operands SHALL be sampled only at the accept edge; later changes on A/B SHALL not affect the result.
REQ-025 HI/LO SHALL hold their value while busy; the old values remain readable during RUN.

Reset
REQ-026 reset=0 SHALL, asynchronously and irrespective of clk, force:
- state IDLE
- counter 0
- busy 0
- HI 0
- LO 0
- latched operands 0
REQ-027 Reset asserted mid-operation SHALL discard the pending result. After release, the first accepted start behaves as from power-up.

Verification
REQ-028 Scenario 1: mult, A=0xFFFFFFFE, B=3, default parameters -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 Scenario 2: multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 Scenario 3: div, A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu on the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 Scenario 4: preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 -> busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
REQ-032 Scenario 5: mult 2*3 accepted; on cycle 2 of RUN, start=1 with op=mtlo and A=0x55; on cycle 3, start=1 with op=div -> both requests ignored; after 5 cycles, HI=0, LO=6.
REQ-033 Scenario 6: divu 100/7 accepted; reset pulsed low for half a clock at cycle 4 -> busy, HI and LO drop to 0 immediately, and no result appears later. A new multu 4*5 then gives LO=20 after 5 cycles.
